// File: rtl/rr_req_arbiter8.sv
// Round-robin arbiter over N level-sensitive requesters with a registered one-hot
// grant, a hold-time limit per winner and a one-bubble release between grants.
module rr_req_arbiter8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDXW     = $clog2(N),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            busy_o,
  output logic            timeout_pulse_o
);

  localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  logic            win_vld;
  logic [IDXW-1:0] win_idx;
  int unsigned     cand;

  // First requester at or after ptr, wrapping explicitly so non-power-of-two N works.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      if (!win_vld && req_i[IDXW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i && win_vld) begin
          state_d    = GRANT;
          gnt_d      = N'(1) << win_idx;
          gnt_idx_d  = win_idx;
          busy_d     = 1'b1;
          ptr_d      = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
          hold_cnt_d = HCW'(1);
        end
      end
      GRANT: begin
        // A dropped request wins over a coinciding timeout, so no pulse then.
        if (!en_i || !req_i[gnt_idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD))) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign gnt_idx_o       = gnt_idx_q;
  assign busy_o          = busy_q;
  assign timeout_pulse_o = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter8.sv
// Bench for rr_req_arbiter8: directed scenarios plus randomized traffic checked
// against an integer-level round-robin reference model.
module tb_rr_req_arbiter8;

  localparam int unsigned N        = 8;
  localparam int unsigned IDXW     = 3;
  localparam int unsigned MAX_HOLD = 16;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            busy;
  logic            timeout_pulse;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_req_arbiter8 #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_i            (en),
    .req_i           (req),
    .gnt_o           (gnt),
    .gnt_idx_o       (gnt_idx),
    .busy_o          (busy),
    .timeout_pulse_o (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs held before the edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      if (en && req != '0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req[c]) begin
            m_idx  = c;
            m_ptr  = (c + 1) % N;
            m_busy = 1;
            m_hold = 1;
            break;
          end
        end
      end
    end else if (!en || !req[m_idx]) begin
      m_busy = 0;
    end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
      m_busy = 0;
      m_to   = 1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = m_busy ? (N'(1) << m_idx) : '0;
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".to"}, 32'(timeout_pulse), 32'(m_to));
    chk({tag, ".busy_or"}, 32'(busy), 32'(|gnt));
    chk({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'(1));
  endtask

  // Advance one edge, update the model, then sample clear of the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    model_reset();
    #2;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.idx", 32'(gnt_idx), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.to", 32'(timeout_pulse), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: enabled, no requests
    en = 1'b1;
    for (int i = 0; i < 5; i++) step("t1");

    // T2: 0 wins from ptr=0, then 7 after the bubble
    req = 8'h81;
    step("t2a");
    chk("t2.gnt0", 32'(gnt), 32'h01);
    req = 8'h80;
    step("t2b");
    chk("t2.bubble", 32'(gnt), 32'h00);
    step("t2c");
    chk("t2.gnt7", 32'(gnt), 32'h80);
    chk("t2.idx7", 32'(gnt_idx), 32'd7);
    req = 8'h00;
    step("t2d");

    // T3: full rotation with each winner dropping after two grant cycles
    req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      step("t3g");
      chk("t3.idx", 32'(gnt_idx), 32'(k % 8));
      step("t3h");
      req = 8'hFF & ~(8'h01 << (k % 8));
      step("t3r");
      chk("t3.bubble", 32'(gnt), 32'h00);
      req = 8'hFF;
    end
    req = 8'h00;
    step("t3z");

    // T4: single requester hits the hold limit
    req = 8'h08;
    for (int c = 0; c < 16; c++) begin
      step("t4h");
      chk("t4.held", 32'(gnt), 32'h08);
    end
    step("t4t");
    chk("t4.to_gnt", 32'(gnt), 32'h00);
    chk("t4.to_pulse", 32'(timeout_pulse), 32'h1);
    step("t4g");
    chk("t4.regnt", 32'(gnt), 32'h08);
    chk("t4.pulse_end", 32'(timeout_pulse), 32'h0);
    req = 8'h00;
    step("t4z");

    // T5: disable releases, re-enable scans from ptr=3
    req = 8'h04;
    step("t5a");
    chk("t5.gnt2", 32'(gnt), 32'h04);
    en = 1'b0;
    step("t5b");
    chk("t5.off", 32'(busy), 32'h0);
    en  = 1'b1;
    req = 8'h24;
    step("t5c");
    chk("t5.gnt5", 32'(gnt), 32'h20);
    req = 8'h00;
    step("t5z");

    // T6: async reset mid-cycle during a grant
    req = 8'h10;
    step("t6a");
    chk("t6.gnt4", 32'(gnt), 32'h10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6.async_gnt", 32'(gnt), 32'h0);
    chk("t6.async_idx", 32'(gnt_idx), 32'h0);
    chk("t6.async_busy", 32'(busy), 32'h0);
    step("t6r");
    #2;
    rst_n = 1'b1;
    req   = 8'h11;
    step("t6b");
    chk("t6.scan0", 32'(gnt), 32'h01);
    req = 8'h00;
    step("t6z");

    // Randomized traffic with sticky requests so hold limits are reached
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step("rnd_rst");
        rst_n = 1'b1;
      end
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
